// File: rtl/ll_control.sv
// Lunar-lander sequencing controller: paces simulation steps, commits ALU
// results through wen, holds pending thrust and display selection, and classifies touchdown.
module ll_control #(
  parameter int          STEP_CYCLES = 25,
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter logic [15:0] CRASH_VEL   = 16'h9970,
  parameter logic [15:0] MAX_THRUST  = 16'h0005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_strobe,
  input  logic [4:0]  key_code,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [15:0] thrust,
  input  logic [15:0] alt_n,
  input  logic [15:0] vel_n,
  output logic        wen,
  output logic [15:0] thrust_n,
  output logic [1:0]  disp_sel,
  output logic        land,
  output logic        crash
);

  // state    | meaning
  // ST_INIT  | one cycle after reset
  // ST_WAIT  | pacing delay, STEP_CYCLES cycles
  // ST_CALC  | ALU next values settled; touchdown check
  // ST_SET   | commit ALU results into memory (wen)
  // ST_LAND  | safe touchdown, terminal until reset
  // ST_CRASH | crash touchdown, terminal until reset
  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT,
    ST_CALC,
    ST_SET,
    ST_LAND,
    ST_CRASH
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [15:0] NEG_LIMIT = 16'h5000;

  state_t     state, state_nxt;
  logic [7:0] step_cnt;
  logic       step_done;
  logic       touchdown;
  logic       vel_crash;
  logic       thrust_crash;
  logic       crash_cond;
  logic       terminal;
  logic       fuel_empty;
  logic       thrust_key;
  logic       disp_key;

  // Current alt/vel are not needed for sequencing; only next values decide touchdown.
  logic unused_ok;
  assign unused_ok = ^{alt, vel};

  assign step_done    = (step_cnt == STEP_LAST);
  assign touchdown    = (alt_n == 16'h0000) || (alt_n >= NEG_LIMIT);
  assign vel_crash    = (vel_n >= NEG_LIMIT) && (vel_n <= CRASH_VEL);
  assign thrust_crash = (thrust > MAX_THRUST);
  assign crash_cond   = vel_crash || thrust_crash;
  assign terminal     = (state == ST_LAND) || (state == ST_CRASH);
  assign fuel_empty   = (fuel == 16'h0000);
  assign thrust_key   = key_strobe && (key_code <= 5'd9);
  assign disp_key     = key_strobe && (key_code[4:2] == 3'b100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  state_nxt = ST_WAIT;
      ST_WAIT:  if (step_done) state_nxt = ST_CALC;
      ST_CALC: begin
        if (!touchdown) begin
          state_nxt = ST_SET;
        end else if (crash_cond) begin
          state_nxt = ST_CRASH;
        end else begin
          state_nxt = ST_LAND;
        end
      end
      ST_SET:   state_nxt = ST_WAIT;
      ST_LAND:  state_nxt = ST_LAND;
      ST_CRASH: state_nxt = ST_CRASH;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= 8'd0;
    end else if (state == ST_WAIT && !step_done) begin
      step_cnt <= step_cnt + 8'd1;
    end else begin
      step_cnt <= 8'd0;
    end
  end

  // Moore decode: a reset during SET drops wen at once, so no partial write follows.
  assign wen = (state == ST_SET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      land  <= 1'b0;
      crash <= 1'b0;
    end else if (state == ST_CALC) begin
      land  <= (state_nxt == ST_LAND);
      crash <= (state_nxt == ST_CRASH);
    end
  end

  // Fuel-empty forcing wins over a thrust key in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thrust_n <= THRUST_INIT;
    end else if (fuel_empty) begin
      thrust_n <= 16'h0000;
    end else if (thrust_key && !terminal) begin
      thrust_n <= {12'h000, key_code[3:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_sel <= 2'd0;
    end else if (disp_key) begin
      disp_sel <= ~key_code[1:0];
    end
  end

endmodule

// File: tb/tb_ll_control.sv
// Directed bench for ll_control with a step-timeline model checked every cycle.
module tb_ll_control;

  localparam int STEP = 25;
  localparam int PER  = STEP + 2;

  logic        clk;
  logic        rst;
  logic        key_strobe;
  logic [4:0]  key_code;
  logic [15:0] alt, vel, fuel, thrust, alt_n, vel_n;
  logic        wen;
  logic [15:0] thrust_n;
  logic [1:0]  disp_sel;
  logic        land, crash;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  ll_control #(
    .STEP_CYCLES(STEP),
    .THRUST_INIT(16'h0005),
    .CRASH_VEL(16'h9970),
    .MAX_THRUST(16'h0005)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_strobe(key_strobe),
    .key_code(key_code),
    .alt(alt),
    .vel(vel),
    .fuel(fuel),
    .thrust(thrust),
    .alt_n(alt_n),
    .vel_n(vel_n),
    .wen(wen),
    .thrust_n(thrust_n),
    .disp_sel(disp_sel),
    .land(land),
    .crash(crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_k counts edges since reset release; SET lands on every multiple of PER,
  // CALC on the edge just before it. m_term: 0 flying, 1 landed, 2 crashed.
  int          m_k    = 0;
  int          m_term = 0;
  logic [15:0] m_thr  = 16'h0005;
  logic [1:0]  m_disp = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    <= 0;
      m_term <= 0;
      m_thr  <= 16'h0005;
      m_disp <= 2'd0;
    end else begin
      if (fuel == 16'h0000)
        m_thr <= 16'h0000;
      else if (key_strobe && key_code <= 5'd9 && m_term == 0)
        m_thr <= {12'h000, key_code[3:0]};
      if (key_strobe && key_code >= 5'd16 && key_code <= 5'd19)
        m_disp <= 2'(19 - int'(key_code));
      if (m_term == 0 && (m_k % PER) == PER - 1) begin
        if (alt_n == 16'h0000 || alt_n >= 16'h5000) begin
          if ((vel_n >= 16'h5000 && vel_n <= 16'h9970) || thrust > 16'h0005)
            m_term <= 2;
          else
            m_term <= 1;
        end
      end
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_wen", 16'(wen), 16'(m_term == 0 && m_k > 0 && (m_k % PER) == 0));
      chk("cmp_thrust_n", thrust_n, m_thr);
      chk("cmp_disp_sel", 16'(disp_sel), 16'(m_disp));
      chk("cmp_land", 16'(land), 16'(m_term == 1));
      chk("cmp_crash", 16'(crash), 16'(m_term == 2));
    end
  end

  task automatic key(input logic [4:0] c);
    key_code   = c;
    key_strobe = 1'b1;
    @(negedge clk);
    key_strobe = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int budget, input string nm);
    int n = 0;
    logic s;
    s = (which == 0) ? wen : (which == 1) ? land : crash;
    while (!s && n < budget) begin
      @(negedge clk);
      n++;
      s = (which == 0) ? wen : (which == 1) ? land : crash;
    end
    chk(nm, 16'(s), 16'd1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wen"}, 16'(wen), 16'd0);
    chk({tag, "_thrust_n"}, thrust_n, 16'h0005);
    chk({tag, "_disp_sel"}, 16'(disp_sel), 16'd0);
    chk({tag, "_land"}, 16'(land), 16'd0);
    chk({tag, "_crash"}, 16'(crash), 16'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_checks(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mem_default();
    alt = 16'h4500; vel = 16'h0000; fuel = 16'h0800; thrust = 16'h0005;
    alt_n = 16'h4500; vel_n = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    rst = 1'b0; key_strobe = 1'b0; key_code = 5'd0;
    mem_default();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    reset_checks("rst0");
    rst = 1'b0;

    // Step pacing: wen at edges 27 and 54 only
    repeat (26) @(negedge clk);
    chk("wen_c26", 16'(wen), 16'd0);
    @(negedge clk);
    chk("wen_c27", 16'(wen), 16'd1);
    @(negedge clk);
    chk("wen_c28", 16'(wen), 16'd0);
    repeat (26) @(negedge clk);
    chk("wen_c54", 16'(wen), 16'd1);
    repeat (3) @(negedge clk);

    key(5'd9);  chk("key9", thrust_n, 16'h0009);
    key(5'd12); chk("key12_ignored", thrust_n, 16'h0009);
    key(5'd19); chk("keyZ", 16'(disp_sel), 16'd0);
    key(5'd16); chk("keyW", 16'(disp_sel), 16'd3);
    key(5'd5);  chk("key5", thrust_n, 16'h0005);

    // Key during SET: memory sees old thrust_n at that edge
    wait_sig(0, 60, "wait_set");
    chk("thr_in_set", thrust_n, 16'h0005);
    key(5'd3);
    chk("thr_after_set", thrust_n, 16'h0003);

    // Safe landing
    alt_n = 16'h9990; vel_n = 16'h9985; thrust = 16'h0005;
    wait_sig(1, 60, "wait_land");
    chk("land_crash0", 16'(crash), 16'd0);
    wc = 0;
    repeat (200) begin
      @(negedge clk);
      if (wen) wc++;
    end
    chk("no_wen_after_land", 16'(wc), 16'd0);
    key(5'd7);  chk("land_key7_ignored", thrust_n, 16'h0003);
    key(5'd18); chk("land_keyY", 16'(disp_sel), 16'd1);

    // Crash on velocity exactly at the limit, with exact timing
    do_reset("rst_a");
    alt_n = 16'h0000; vel_n = 16'h9970; thrust = 16'h0005;
    repeat (26) @(negedge clk);
    chk("crashA_c26", 16'(crash), 16'd0);
    @(negedge clk);
    chk("crashA_c27", 16'(crash), 16'd1);
    chk("crashA_land0", 16'(land), 16'd0);
    chk("crashA_wen0", 16'(wen), 16'd0);

    // Crash on excess thrust
    do_reset("rst_b");
    alt_n = 16'h0000; vel_n = 16'h0000; thrust = 16'h0006;
    wait_sig(2, 60, "wait_crashB");
    chk("crashB_land0", 16'(land), 16'd0);

    // Boundary: alt_n 5000 is touchdown, vel_n 9971 is just too slow to crash
    do_reset("rst_c");
    alt_n = 16'h5000; vel_n = 16'h9971; thrust = 16'h0005;
    wait_sig(1, 60, "wait_landC");
    chk("landC_crash0", 16'(crash), 16'd0);

    // Fuel empty
    do_reset("rst_d");
    mem_default();
    repeat (3) @(negedge clk);
    key(5'd9); chk("fuel_key9", thrust_n, 16'h0009);
    fuel = 16'h0000;
    @(negedge clk);
    chk("fuel_forced0", thrust_n, 16'h0000);
    key(5'd4);  chk("fuel_key4_ignored", thrust_n, 16'h0000);
    key(5'd17); chk("fuel_keyX", 16'(disp_sel), 16'd2);
    fuel = 16'h0800;

    // Reset mid-WAIT restarts the step counter
    repeat (5) @(negedge clk);
    key(5'd16); chk("pre_rst_keyW", 16'(disp_sel), 16'd3);
    do_reset("rst_e");
    repeat (26) @(negedge clk);
    chk("rst_e_c26", 16'(wen), 16'd0);
    @(negedge clk);
    chk("rst_e_c27", 16'(wen), 16'd1);
    @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ll_control.md
# ll_control

Sequencing controller for the lunar-lander datapath, sitting between the pushbutton synchronizer, `ll_memory` and `ll_alu`.
- Paces simulation steps from the 100 Hz clock and issues the one-cycle `wen` that commits ALU results into memory.
- Owns the pending-thrust register and the display-quantity selection.
- Detects touchdown and classifies it as a landing or a crash.
- All quantities are 4-digit BCD, ten's complement: a value is negative when its top digit is ≥5.

## Interface
Parameters:
- `STEP_CYCLES`, 25 — WAIT-state length in clk cycles; legal range 1..255.
- `THRUST_INIT`, 16'h0005 — reset value of `thrust_n`.
- `CRASH_VEL`, 16'h9970 — BCD −30. A negative velocity ≤ this value is a crash.
- `MAX_THRUST`, 16'h0005 — thrust above this value at touchdown is a crash.

Ports:
- `clk` in 1 — system clock, 100 Hz (`hz100`).
- `rst` in 1 — reset, asynchronous, active-high.
- `key_strobe` in 1 — one-cycle pulse, already synchronized, marks a valid `key_code`.
- `key_code` in 5 — 0..9 are thrust digits; 16=W, 17=X, 18=Y, 19=Z; all other codes are ignored.
- `alt`, `vel`, `fuel`, `thrust` in 16 each — current values from `ll_memory`.
- `alt_n`, `vel_n` in 16 each — next values from `ll_alu`.
- `wen` out 1 — memory write enable.
- `thrust_n` out 16 — pending thrust, fed to `ll_memory.thrust_n`.
- `disp_sel` out 2 — display quantity: 0 alt, 1 vel, 2 fuel, 3 thrust.
- `land` out 1 — safe touchdown; sticky until reset.
- `crash` out 1 — crash touchdown; sticky until reset.

## Operation
- FSM states: INIT, WAIT, CALC, SET, LAND, CRASH.
- INIT → WAIT unconditionally after one cycle.
- WAIT: the step counter increments each cycle. When count = `STEP_CYCLES`−1, go to CALC and clear the counter.
- CALC (one cycle):
  - Touchdown is true when `alt_n` == 0 or `alt_n[15:12]` ≥ 5.
  - Touchdown with crash condition → CRASH. Crash condition is (`vel_n[15:12]` ≥ 5 and `vel_n` ≤ `CRASH_VEL`) or `thrust` > `MAX_THRUST`.
  - Touchdown without crash condition → LAND.
  - No touchdown → SET.
  - All comparisons are unsigned 16-bit; BCD ordering matches binary ordering.
- SET: `wen` = 1 for this one cycle only, then → WAIT.
- LAND and CRASH are terminal until `rst`. No `wen` is issued on the touchdown step, so memory keeps its last pre-touchdown values.
- `wen` is a Moore output: 1 only in SET.
- `land` and `crash` are registered and go to 1 on entering their state. They are never both 1.
- Thrust keys (`key_strobe` with code 0..9):
  - `thrust_n` ← {12'h000, code[3:0]}.
  - Accepted in INIT, WAIT, CALC and SET; ignored in LAND and CRASH.
- Display keys (codes 16..19): `disp_sel` ← ~code[1:0], so Z→0, Y→1, X→2, W→3. Accepted in every state, including terminal ones.
- Fuel empty: when `fuel` == 16'h0000, `thrust_n` is forced to 0 on every edge and thrust keys are ignored. Display keys still work.

## Timing
- Reset values:
  - state INIT, counter 0
  - `wen` 0
  - `thrust_n` = `THRUST_INIT`
  - `disp_sel` 0
  - `land` 0, `crash` 0
- `rst` is asynchronous in any state, including mid-step or in SET: all outputs return to reset values immediately, and no partial write may follow release.
- Step period is `STEP_CYCLES` + 2 cycles (WAIT + CALC + SET). With the default this is 27 cycles = 270 ms.
- First `wen` comes `STEP_CYCLES` + 2 cycles after reset release (INIT + WAIT + CALC).
- Key latency: the register updates at the edge that samples `key_strobe`, so a strobe in cycle n is visible in cycle n+1.
- Key strobe in a SET cycle: memory captures the old `thrust_n` at that edge, and the new value applies from the next step.
- Touchdown classification uses `alt_n`, `vel_n` and `thrust` as sampled in the CALC cycle. `land` or `crash` is asserted one cycle after CALC.
- Fuel-empty forcing takes priority over a thrust key arriving in the same cycle.

## Test plan
- Reset release, no keys, memory at 4500/0/800/5, `STEP_CYCLES`=25 → `wen` pulses one cycle wide at cycle 27, 54, 81, …; `thrust_n`=0005; `disp_sel`=0.
- `key_strobe` with code 9 in WAIT → `thrust_n`=0009 next cycle. Code 12 → no change. Code 19 then code 16 → `disp_sel` 0 then 3.
- Strobe code 3 in the SET cycle while `thrust_n`=0005 → memory writes thrust 0005; `thrust_n`=0003 the next cycle.
- CALC with `alt_n`=9990, `vel_n`=9985 (−15), `thrust`=0005 → LAND; `land`=1, `crash`=0, no further `wen` for 200 cycles; code 7 ignored; code 18 still gives `disp_sel`=1.
- CALC with `alt_n`=0000 and either `vel_n`=9970 or `thrust`=0006 → CRASH; `crash`=1, `land`=0.
- `fuel`=0000 with `thrust_n`=0009 → `thrust_n`=0000 next cycle, and a code-4 strobe is ignored. Separately, `rst` pulsed mid-WAIT → all outputs return to reset values and the counter restarts.
